// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480@60 VGA timing generator driven by the ~25 MHz pixel clock.
//            Stage 0 holds the raw h/v counters. Stage 1 holds their registered
//            decodes (x, y, active, line/frame strobes, frame counter) for the
//            renderer. Stage 2 holds the registered colour and the syncs, so the
//            syncs on the pins stay aligned with the colour.
// Ports    : clk          pixel clock
//            n_rst        asynchronous active-low reset
//            en           run enable (low = timing held at origin)
//            rgb_in[2:0]  renderer colour for the stage-1 (x,y)
//            x[9:0]       stage-1 column, 0..H_TOTAL-1
//            y[9:0]       stage-1 row, 0..V_TOTAL-1
//            active       stage-1 visible-area flag
//            line_start   stage-1 pulse at x==0
//            frame_start  stage-1 pulse at x==0 && y==0
//            frame_count  completed frames, wraps 255->0
//            hsync/vsync  stage-2 syncs, asserted level = SYNC_POL
//            rgb_out[2:0] stage-2 colour, 0 outside active video
// Config   : VGA_TEST_PATTERN_EN - when defined, rgb_in is ignored and the
//            active area shows vertical bars equal to x[9:7].
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic [2:0] rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  // Set for the single cycle in which stage 0 sits at the origin because the
  // previous frame completed (as opposed to being cleared by en/reset).
  logic       r_wrap;
  // Low only in the first cycle after reset release; the counters spend that
  // cycle settling at the origin so the first frame_start comes one edge later.
  logic       r_armed;

  logic       w_run;
  logic [2:0] w_colour;

  assign w_run = en & r_armed;

`ifdef VGA_TEST_PATTERN_EN
  // rgb_in is deliberately ignored in this build; the zero mask keeps the
  // port referenced so both builds share one port list.
  assign w_colour = x[9:7] | (rgb_in & 3'b000);
`else
  assign w_colour = rgb_in;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_armed     <= 1'b0;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_wrap      <= 1'b0;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      rgb_out     <= '0;
    end else begin
      r_armed <= 1'b1;

      if (w_run) begin
        // Stage 0: free-running raster counters
        r_wrap <= (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end

        // Stage 1: decodes of the stage-0 position
        x           <= r_h_cnt;
        y           <= r_v_cnt;
        active      <= (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
        line_start  <= (r_h_cnt == 10'd0);
        frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
        // Counting on the stage-1 edge makes the wrap coincide with frame_start.
        if (r_wrap) begin
          frame_count <= frame_count + 8'd1;
        end

        // Stage 2: pin-side colour and syncs from the stage-1 position
        rgb_out <= active ? w_colour : 3'b000;
        hsync   <= ((x >= HS_START) && (x < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync   <= ((y >= VS_START) && (y < VS_END)) ? SYNC_POL : ~SYNC_POL;
      end else begin
        r_h_cnt     <= '0;
        r_v_cnt     <= '0;
        r_wrap      <= 1'b0;
        x           <= '0;
        y           <= '0;
        active      <= 1'b0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
        rgb_out     <= '0;
        hsync       <= ~SYNC_POL;
        vsync       <= ~SYNC_POL;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen. A reference model tracks the
//            raster as a linear position within the frame and derives every
//            output from the timing rules; its predictions are queued each
//            cycle and a monitor compares them against the DUT on the falling
//            edge. Uses a reduced raster so frame_count can wrap quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 9
  localparam int FRAME = HT * VT;          // 144
  localparam logic POL = 1'b0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } obs_t;

  logic       clk;
  logic       n_rst;
  logic       en;
  logic [2:0] rgb_in;
  logic [9:0] x, y;
  logic       active, line_start, frame_start;
  logic [7:0] frame_count;
  logic       hsync, vsync;
  logic [2:0] rgb_out;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk), .n_rst(n_rst), .en(en), .rgb_in(rgb_in),
    .x(x), .y(y), .active(active), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count),
    .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wraps_seen = 0;
  bit   done = 1'b0;

  function automatic bit in_rng(int v, int lo, int hi);
    return (v >= lo) && (v < hi);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_rst  = 1'b0;
    en     = 1'b0;
    rgb_in = 3'b000;
    repeat (3) @(posedge clk);
    #2;
    n_rst  = 1'b1;
    en     = 1'b1;
    rgb_in = 3'b101;
    // Constant colour for a few lines, then randomized en drops and resets.
    repeat (3 * HT) @(posedge clk);
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #2;
      if (!n_rst) n_rst = ($urandom_range(0, 1) == 1);
      else        n_rst = ($urandom_range(0, 499) != 0);
      en     = ($urandom_range(0, 99) >= 3);
      rgb_in = 3'($urandom);
    end
    // Long uninterrupted run: more than 256 frames so frame_count wraps.
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 257 * FRAME + 50; i++) begin
      @(posedge clk);
      #2;
      rgb_in = 3'($urandom);
    end
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  // ---------------- reference model ----------------
  initial begin : model
    int   pos0;
    int   frames;
    bit   armed;
    bit   wrapped;
    bit   run;
    bit   en_s, rst_s;
    logic [2:0] rgb_s;
    obs_t s;
    pos0 = 0; frames = 0; armed = 0; wrapped = 0;
    s = '0; s.hs = ~POL; s.vs = ~POL;
    forever begin
      @(posedge clk);
      en_s  = en;
      rst_s = n_rst;
      rgb_s = rgb_in;
      #3;
      if (!rst_s || !n_rst) begin
        pos0 = 0; frames = 0; armed = 0; wrapped = 0;
        s = '0; s.hs = ~POL; s.vs = ~POL;
      end else begin
        run = en_s && armed;
        // pin side: colour and syncs follow the previous stage-1 position
        if (run) begin
`ifdef VGA_TEST_PATTERN_EN
          s.rgb = s.active ? 3'(s.x >> 7) : 3'b000;
`else
          s.rgb = s.active ? rgb_s : 3'b000;
`endif
          s.hs = in_rng(int'(s.x), HA + HF, HA + HF + HS) ? POL : ~POL;
          s.vs = in_rng(int'(s.y), VA + VF, VA + VF + VS) ? POL : ~POL;
        end else begin
          s.rgb = 3'b000; s.hs = ~POL; s.vs = ~POL;
        end
        // renderer side: decode of the raster position
        if (run) begin
          s.x      = 10'(pos0 % HT);
          s.y      = 10'(pos0 / HT);
          s.active = ((pos0 % HT) < HA) && ((pos0 / HT) < VA);
          s.ls     = ((pos0 % HT) == 0);
          s.fs     = (pos0 == 0);
          if (pos0 == 0 && wrapped) frames++;
        end else begin
          s.x = '0; s.y = '0; s.active = 0; s.ls = 0; s.fs = 0;
        end
        s.fc = 8'(frames);
        // raster advance
        if (run) begin
          wrapped = (pos0 == FRAME - 1);
          pos0 = (pos0 + 1) % FRAME;
        end else begin
          pos0 = 0; wrapped = 0;
        end
        armed = 1;
      end
      exp_q.push_back(s);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    obs_t a, e;
    logic [7:0] prev_fc;
    int cyc;
    prev_fc = 8'd0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      a = '{x: x, y: y, active: active, ls: line_start, fs: frame_start,
            fc: frame_count, hs: hsync, vs: vsync, rgb: rgb_out};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL no_expectation cycle %0d: got %h, required an entry", cyc, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got x=%0d y=%0d act=%b ls=%b fs=%b fc=%0d hs=%b vs=%b rgb=%b, required x=%0d y=%0d act=%b ls=%b fs=%b fc=%0d hs=%b vs=%b rgb=%b",
                   cyc, a.x, a.y, a.active, a.ls, a.fs, a.fc, a.hs, a.vs, a.rgb,
                   e.x, e.y, e.active, e.ls, e.fs, e.fc, e.hs, e.vs, e.rgb);
        end
      end
      // the 255->0 roll-over must land on a frame_start pulse
      if (n_rst && prev_fc == 8'd255 && frame_count == 8'd0) begin
        wraps_seen++;
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL fc_wrap_align cycle %0d: got frame_start=%b, required 1", cyc, frame_start);
        end
      end
      prev_fc = frame_count;
    end
  end

  // ---------------- end of test ----------------
  initial begin
    wait (done);
    @(negedge clk);
    #1;
    n_checks++;
    if (wraps_seen < 1) begin
      n_fail++;
      $display("FAIL fc_wrap_seen: got %0d roll-overs, required at least 1", wraps_seen);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound in case the stimulus process stalls.
  initial begin
    #5_000_000;
    $display("FAIL timeout: got no completion, required completion within bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
